// File: rtl/branch_resolve_unit.sv
// RV32I branch/jump resolution with a bimodal BHT; 1-cycle latency, one output register.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module branch_resolve_unit #(
   parameter int XLEN         = 32,
   parameter int BHT_DEPTH    = 16,
   parameter int CTR_BITS     = 2,
   parameter int SUPPORT_JUMP = 1,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          inst,
   input  logic [XLEN-1:0]      pc,
   input  logic [XLEN-1:0]      rs1_data,
   input  logic [XLEN-1:0]      rs2_data,
   input  logic                 pred_taken,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_is_branch,
   output logic                 out_taken,
   output logic [XLEN-1:0]      out_target,
   output logic [XLEN-1:0]      out_redirect_pc,
   output logic                 out_mispredict,
   output logic                 out_illegal,
   output logic [XLEN-1:0]      out_link,
   input  logic [XLEN-1:0]      lookup_pc,
   output logic                 lookup_taken,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [XLEN-1:0] W_FOUR = XLEN'(4);
   localparam logic [XLEN-1:0] W_LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic            w_is_br, w_is_jal, w_is_jalr, w_illegal;
   logic [XLEN-1:0] w_imm_b, w_imm_j, w_imm_i, w_seq_pc;
   logic            w_eq, w_lt, w_ltu, w_cond, w_taken, w_mispredict;
   logic [XLEN-1:0] w_target, w_redirect, w_link;
   logic            w_in_fire, w_out_fire, w_train;
   logic [IDX_W-1:0] w_lookup_idx;
   logic            w_unused_bits;

   logic            r_out_valid, r_is_branch, r_taken, r_mispredict, r_illegal;
   logic [XLEN-1:0] r_target, r_redirect, r_link;
   logic [IDX_W-1:0] r_idx;
   logic [CTR_BITS-1:0] r_bht [BHT_DEPTH];
   logic [CNT_WIDTH-1:0] r_branch_cnt, r_misp_cnt;

   assign w_opcode  = inst[6:0];
   assign w_funct3  = inst[14:12];
   assign w_is_br   = (w_opcode == OP_BRANCH) && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
   assign w_is_jal  = (SUPPORT_JUMP != 0) && (w_opcode == OP_JAL);
   assign w_is_jalr = (SUPPORT_JUMP != 0) && (w_opcode == OP_JALR) && (w_funct3 == 3'b000);
   assign w_illegal = !(w_is_br || w_is_jal || w_is_jalr);

   assign w_imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign w_imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign w_imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign w_seq_pc = pc + W_FOUR;

   assign w_eq  = (rs1_data == rs2_data);
   assign w_lt  = ($signed(rs1_data) < $signed(rs2_data));
   assign w_ltu = (rs1_data < rs2_data);

   // funct3[2:1] picks the relation, funct3[0] inverts it (NE/GE/GEU).
   always_comb begin
      w_cond = 1'b0;
      case (w_funct3[2:1])
         2'b00:   w_cond = w_eq;
         2'b10:   w_cond = w_lt;
         2'b11:   w_cond = w_ltu;
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      w_target = w_seq_pc;
      if (w_is_jalr)     w_target = (rs1_data + w_imm_i) & W_LSB_CLR;
      else if (w_is_jal) w_target = pc + w_imm_j;
      else if (w_is_br)  w_target = pc + w_imm_b;
   end

   assign w_taken      = (w_is_br && (w_cond ^ w_funct3[0])) || w_is_jal || w_is_jalr;
   assign w_redirect   = w_taken ? w_target : w_seq_pc;
   assign w_link       = (w_is_jal || w_is_jalr) ? w_seq_pc : '0;
   assign w_mispredict = (w_taken != pred_taken);

   assign in_ready   = !r_out_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready && !flush;
   assign w_out_fire = r_out_valid && out_ready && !flush;
   assign w_train    = w_out_fire && r_is_branch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_is_branch  <= 1'b0;
         r_taken      <= 1'b0;
         r_mispredict <= 1'b0;
         r_illegal    <= 1'b0;
         r_target     <= '0;
         r_redirect   <= '0;
         r_link       <= '0;
         r_idx        <= '0;
      end else begin
         if (flush)         r_out_valid <= 1'b0;
         else if (in_ready) r_out_valid <= in_valid;
         if (w_in_fire) begin
            r_is_branch  <= w_is_br;
            r_taken      <= w_taken;
            r_mispredict <= w_mispredict;
            r_illegal    <= w_illegal;
            r_target     <= w_target;
            r_redirect   <= w_redirect;
            r_link       <= w_link;
            r_idx        <= pc[IDX_W+1:2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CTR_INIT;
      end else if (w_train) begin
         if (r_taken && (r_bht[r_idx] != CTR_MAX))
            r_bht[r_idx] <= r_bht[r_idx] + CTR_BITS'(1);
         else if (!r_taken && (r_bht[r_idx] != '0))
            r_bht[r_idx] <= r_bht[r_idx] - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_cnt <= '0;
         r_misp_cnt   <= '0;
      end else if (w_out_fire) begin
         r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(r_is_branch);
         r_misp_cnt   <= r_misp_cnt + CNT_WIDTH'(r_mispredict);
      end
   end

   // Lookup reads the pre-update array; a same-cycle training write lands at the edge.
   assign w_lookup_idx  = lookup_pc[IDX_W+1:2];
   assign lookup_taken  = r_bht[w_lookup_idx][CTR_BITS-1];
   assign w_unused_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

   assign out_valid        = r_out_valid;
   assign out_is_branch    = r_is_branch;
   assign out_taken        = r_taken;
   assign out_target       = r_target;
   assign out_redirect_pc  = r_redirect;
   assign out_mispredict   = r_mispredict;
   assign out_illegal      = r_illegal;
   assign out_link         = r_link;
   assign branch_count     = r_branch_cnt;
   assign mispredict_count = r_misp_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: behavioural model + per-cycle compare, plus literal pins.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] inst = '0, pc = '0, rs1_data = '0, rs2_data = '0;
   logic        pred_taken = 1'b0, flush = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic        out_is_branch, out_taken, out_mispredict, out_illegal;
   logic [31:0] out_target, out_redirect_pc, out_link;
   logic [31:0] lookup_pc = '0;
   logic        lookup_taken;
   logic [31:0] branch_count, mispredict_count;

   int n_assert = 0;
   int n_fail   = 0;

   branch_resolve_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_is_branch(out_is_branch), .out_taken(out_taken), .out_target(out_target),
      .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
      .out_illegal(out_illegal), .out_link(out_link), .lookup_pc(lookup_pc),
      .lookup_taken(lookup_taken), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_br, taken, misp, ill;
      logic [31:0] tgt, redir, link;
   } exp_t;

   // Expected result straight from the ISA rules.
   function automatic exp_t model(logic [31:0] ins, logic [31:0] p, logic [31:0] a,
                                  logic [31:0] b, logic pred);
      exp_t e;
      logic [31:0] seq;
      int imm;
      seq = p + 32'd4;
      e = '0;
      e.ill = 1'b1;
      e.tgt = seq;
      if (ins[6:0] == 7'h63 && ins[14:12] != 3'd2 && ins[14:12] != 3'd3) begin
         imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         e.ill = 1'b0;
         e.is_br = 1'b1;
         e.tgt = p + 32'(imm);
         case (ins[14:12])
            3'd0:    e.taken = (a == b);
            3'd1:    e.taken = (a != b);
            3'd4:    e.taken = ($signed(a) < $signed(b));
            3'd5:    e.taken = ($signed(a) >= $signed(b));
            3'd6:    e.taken = (a < b);
            default: e.taken = (a >= b);
         endcase
      end else if (ins[6:0] == 7'h6F) begin
         imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         e.ill = 1'b0; e.taken = 1'b1; e.tgt = p + 32'(imm); e.link = seq;
      end else if (ins[6:0] == 7'h67 && ins[14:12] == 3'd0) begin
         imm = int'($signed(ins[31:20]));
         e.ill = 1'b0; e.taken = 1'b1; e.link = seq;
         e.tgt = (a + 32'(imm)) & 32'hFFFF_FFFE;
      end
      e.redir = e.taken ? e.tgt : seq;
      e.misp  = (e.taken != pred);
      return e;
   endfunction

   function automatic logic [31:0] enc_b(logic [2:0] f3, logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference state: pending result, BHT and counters.
   logic        m_valid = 1'b0;
   exp_t        m_exp = '0;
   int          m_idx = 0;
   int          m_bht [16];
   logic [31:0] m_bc = '0, m_mc = '0;

   initial begin : model_proc
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_valid = 1'b0;
            m_bc = '0;
            m_mc = '0;
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
         end else begin
            if (m_valid && out_ready && !flush) begin
               if (m_exp.is_br) begin
                  if (m_exp.taken) m_bht[m_idx] = (m_bht[m_idx] < 3) ? m_bht[m_idx] + 1 : 3;
                  else             m_bht[m_idx] = (m_bht[m_idx] > 0) ? m_bht[m_idx] - 1 : 0;
                  m_bc = m_bc + 1;
               end
               if (m_exp.misp) m_mc = m_mc + 1;
            end
            if (flush) m_valid = 1'b0;
            else if (!m_valid || out_ready) begin
               m_valid = in_valid;
               if (in_valid) begin
                  m_exp = model(inst, pc, rs1_data, rs2_data, pred_taken);
                  m_idx = int'(pc[5:2]);
               end
            end
         end
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         chk("out_valid", out_valid, m_valid);
         chk("in_ready", in_ready, !m_valid || out_ready);
         chk("branch_count", branch_count, m_bc);
         chk("mispredict_count", mispredict_count, m_mc);
         chk("lookup_taken", lookup_taken, (m_bht[lookup_pc[5:2]] >= 2));
         if (m_valid) begin
            chk("out_is_branch", out_is_branch, m_exp.is_br);
            chk("out_taken", out_taken, m_exp.taken);
            chk("out_target", out_target, m_exp.tgt);
            chk("out_redirect_pc", out_redirect_pc, m_exp.redir);
            chk("out_mispredict", out_mispredict, m_exp.misp);
            chk("out_illegal", out_illegal, m_exp.ill);
            chk("out_link", out_link, m_exp.link);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(logic [31:0] i, logic [31:0] p, logic [31:0] a, logic [31:0] b,
                          logic pr);
      inst = i; pc = p; rs1_data = a; rs2_data = b; pred_taken = pr; in_valid = 1'b1;
   endtask

   task automatic send(logic [31:0] i, logic [31:0] p, logic [31:0] a, logic [31:0] b,
                       logic pr);
      present(i, p, a, b, pr);
      step();
      in_valid = 1'b0;
   endtask

   logic [2:0]  f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [31:0] opa [5] = '{32'h0, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'h8000_0000};
   logic [31:0] opb [5] = '{32'h0, 32'h2, 32'h1, 32'h1, 32'h7FFF_FFFF};

   initial begin : stim
      bit acc;
      int tries;
      step();
      step();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_taken", out_taken, 1'b0);
      chk("rst_out_target", out_target, 32'h0);
      chk("rst_out_redirect", out_redirect_pc, 32'h0);
      chk("rst_out_link", out_link, 32'h0);
      chk("rst_branch_count", branch_count, 32'h0);
      chk("rst_misp_count", mispredict_count, 32'h0);
      chk("rst_lookup", lookup_taken, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // BEQ taken, predicted not-taken
      send(32'h0020_8463, 32'h100, 32'd5, 32'd5, 1'b0);
      lookup_pc = 32'h100;
      @(negedge clk);
      chk("beq_taken", out_taken, 1'b1);
      chk("beq_target", out_target, 32'h108);
      chk("beq_misp", out_mispredict, 1'b1);
      chk("beq_lookup_pre", lookup_taken, 1'b0);
      step();
      @(negedge clk);
      chk("beq_branch_count", branch_count, 32'd1);
      chk("beq_misp_count", mispredict_count, 32'd1);
      chk("beq_lookup_post", lookup_taken, 1'b1);

      // signed vs unsigned compare on the same operands
      send(enc_b(3'b100, 13'd16), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0);
      @(negedge clk);
      chk("blt_taken", out_taken, 1'b1);
      chk("blt_target", out_target, 32'h210);
      send(enc_b(3'b110, 13'd16), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0);
      @(negedge clk);
      chk("bltu_taken", out_taken, 1'b0);
      chk("bltu_redirect", out_redirect_pc, 32'h204);

      // illegal funct3 under the branch opcode, predicted taken
      send(enc_b(3'b010, 13'd8), 32'h300, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      chk("ill_flag", out_illegal, 1'b1);
      chk("ill_taken", out_taken, 1'b0);
      chk("ill_misp", out_mispredict, 1'b1);
      chk("ill_redirect", out_redirect_pc, 32'h304);
      step();
      @(negedge clk);
      chk("ill_branch_count", branch_count, 32'd3);
      chk("ill_misp_count", mispredict_count, 32'd3);
      chk("ill_no_train", lookup_taken, 1'b1);

      // JALR with LSB clear, then JAL backwards
      send(32'h0020_80E7, 32'h400, 32'h2001, 32'd0, 1'b0);
      @(negedge clk);
      chk("jalr_target", out_target, 32'h2002);
      chk("jalr_link", out_link, 32'h404);
      chk("jalr_taken", out_taken, 1'b1);
      chk("jalr_is_branch", out_is_branch, 1'b0);
      send(enc_j(21'h1F_FFF8), 32'h500, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      chk("jal_target", out_target, 32'h4F8);
      chk("jal_link", out_link, 32'h504);
      chk("jal_misp", out_mispredict, 1'b0);
      step();
      @(negedge clk);
      chk("jump_branch_count", branch_count, 32'd3);
      chk("jump_misp_count", mispredict_count, 32'd4);

      // backpressure: A held for three cycles while B waits
      out_ready = 1'b0;
      send(enc_b(3'b001, 13'd32), 32'h600, 32'd1, 32'd2, 1'b1);
      present(enc_b(3'b101, 13'h1FFC), 32'h604, 32'hFFFF_FFFF, 32'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_target", out_target, 32'h620);
         chk("stall_branch_count", branch_count, 32'd3);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", in_ready, 1'b1);
      step();
      present(enc_b(3'b111, 13'h1FFC), 32'h608, 32'hFFFF_FFFF, 32'd0, 1'b0);
      @(negedge clk);
      chk("bge_redirect", out_redirect_pc, 32'h608);
      chk("bge_taken", out_taken, 1'b0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bgeu_target", out_target, 32'h604);
      step();
      @(negedge clk);
      chk("drain_branch_count", branch_count, 32'd6);
      chk("drain_misp_count", mispredict_count, 32'd5);

      // flush kills the registered entry and the presented input
      send(enc_b(3'b000, 13'd8), 32'h700, 32'd0, 32'd0, 1'b0);
      present(enc_b(3'b000, 13'd8), 32'h704, 32'd0, 32'd0, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_branch_count", branch_count, 32'd6);
      chk("flush_misp_count", mispredict_count, 32'd5);
      step();
      @(negedge clk);
      chk("flush_dropped_input", out_valid, 1'b0);

      // table sweep under random backpressure
      for (int f = 0; f < 6; f++) begin
         for (int p = 0; p < 5; p++) begin
            present(enc_b(f3s[f], 13'h1FF0), 32'h1000 + 32'((f * 5 + p) * 4),
                    opa[p], opb[p], 1'((f + p) % 2));
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
               out_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
               acc = in_ready;
               step();
               tries++;
            end
            chk("sweep_accept", acc, 1'b1);
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      step();
      step();

      // saturation on index 0
      lookup_pc = 32'h900;
      for (int k = 0; k < 4; k++) send(enc_b(3'b000, 13'd8), 32'h900, 32'd0, 32'd0, 1'b1);
      step();
      @(negedge clk);
      chk("sat_high", lookup_taken, 1'b1);
      send(enc_b(3'b001, 13'd8), 32'h900, 32'd0, 32'd0, 1'b1);
      step();
      @(negedge clk);
      chk("sat_one_nt", lookup_taken, 1'b1);
      send(enc_b(3'b001, 13'd8), 32'h900, 32'd0, 32'd0, 1'b1);
      step();
      @(negedge clk);
      chk("sat_two_nt", lookup_taken, 1'b0);

      // asynchronous reset with an entry in flight
      lookup_pc = 32'h100;
      out_ready = 1'b0;
      send(enc_b(3'b000, 13'd8), 32'h100, 32'd0, 32'd0, 1'b0);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("areset_out_valid", out_valid, 1'b0);
      chk("areset_branch_count", branch_count, 32'd0);
      chk("areset_misp_count", mispredict_count, 32'd0);
      chk("areset_lookup", lookup_taken, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("post_reset_idle", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined branch resolution stage for the RV32I execute path. Decodes conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and, optionally, JAL/JALR, then compares operands and computes the target. It checks the outcome against the fetch-stage prediction and trains a parametrised bimodal history table (BHT) that fetch reads through a lookup port. It sits between ID/operand fetch and the PC-redirect logic, with a valid/ready handshake and one register stage.

## Interface
- XLEN, 32, datapath and PC width
- BHT_DEPTH, 16, BHT entries; power of two, minimum 2; indexed by pc[log2(BHT_DEPTH)+1 : 2]
- CTR_BITS, 2, saturating counter width, minimum 1; MSB = predict taken
- SUPPORT_JUMP, 1, when 1, JAL/JALR are resolved; when 0, they are treated as illegal
- CNT_WIDTH, 32, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  stage can accept input
- inst  in  32  instruction word
- pc  in  XLEN  instruction PC
- rs1_data, rs2_data  in  XLEN  operand values
- pred_taken  in  1  fetch-stage prediction for this instruction
- flush  in  1  kill the registered entry and the current input
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_is_branch  out  1  conditional branch resolved
- out_taken  out  1  actual direction (jumps: 1)
- out_target  out  XLEN  taken target
- out_redirect_pc  out  XLEN  out_taken ? out_target : pc+4
- out_mispredict  out  1  out_taken != registered pred_taken
- out_illegal  out  1  opcode or funct3 not supported
- out_link  out  XLEN  pc+4 (jumps)
- lookup_pc  in  XLEN  fetch PC for prediction
- lookup_taken  out  1  combinational MSB of the indexed BHT counter
- branch_count, mispredict_count  out  CNT_WIDTH  performance counters

## Operation
- Decode:
  - opcode 1100011 with funct3 000/001/100/101/110/111 maps to EQ/NE/LT/GE/LTU/GEU.
  - funct3 010/011 gives illegal.
  - opcode 1101111 is JAL; 1100111 with funct3 000 is JALR (SUPPORT_JUMP=1 only).
  - Any other opcode gives illegal.
- Immediates are sign-extended to XLEN:
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - I: inst[31:20]
- Targets:
  - Branch and JAL: pc + imm.
  - JALR: (rs1_data + imm) & ~1.
  - All sums are XLEN bits and wrap modulo 2^XLEN.
- Comparisons: LT/GE are signed; LTU/GEU are unsigned.
- Illegal result: taken=0, is_branch=0, target=pc+4; mispredict = pred_taken.
- BHT training:
  - Occurs on an output handshake (out_valid && out_ready) with out_is_branch=1.
  - The counter at the registered pc's index saturates up if taken, down if not.
  - Jumps and illegal instructions do not train the BHT.
- Counters, updated on each output handshake:
  - branch_count +1 on out_is_branch.
  - mispredict_count +1 on out_mispredict.
  - Both wrap at 2^CNT_WIDTH.

## Timing
- Reset values:
  - out_valid=0; all out_* data fields=0; both counters=0.
  - Every BHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2). For CTR_BITS=1 this is 0.
- Latency: exactly 1 cycle. Input accepted at edge N appears on out_* after edge N.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
  - Outputs hold stable while out_valid && !out_ready.
- flush (synchronous, highest priority):
  - Clears out_valid at the next edge and discards any input presented that cycle.
  - A flushed entry does not train the BHT or bump counters, even if out_ready was high.
  - in_ready is unaffected by flush.
- Lookup is combinational. If a lookup hits an index trained in the same cycle, it returns the pre-update value; the new value is visible next cycle.
- Reset mid-operation: an in-flight entry is dropped. BHT and counters return to reset values immediately (asynchronous).

## Test plan
- Reset, then BEQ (inst 0x00208463, pc=0x100, rs1=rs2=5, pred_taken=0) -> out_taken=1, out_target=0x108, out_mispredict=1, branch_count=1, mispredict_count=1. BHT[0] goes 01→10, and lookup_pc=0x100 returns 1 on the next cycle.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, redirect_pc=pc+4.
- funct3=010 under opcode 1100011 -> out_illegal=1, taken=0; with pred_taken=1, mispredict=1. BHT and branch_count are unchanged.
- JALR, rs1=0x2001, imm=+2 -> target=0x2002 (LSB cleared), out_link=pc+4, taken=1, no BHT change.
- Back-to-back branches with out_ready held low for 3 cycles -> in_ready=0, outputs stable, no counter change. Release ready -> one result per cycle, no loss.
- Branch accepted at edge N, flush asserted in cycle N+1 with out_ready=1 -> out_valid=0 after edge N+1. BHT and counters are unchanged, and the input presented during the flush cycle is dropped.
